// File: rtl/sm_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO for the data bus.
// Ports: clk, rst_n, addr/we/wdata (core bus), sel/rdata (read mux), tx (line).
module sm_uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_4000,
    parameter int          CLK_DIV    = 27,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [15:0]   DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count;
    logic          overflow;
    state_t        state, stateNext;
    logic [15:0]   bitCnt, bitCntNext;
    logic [2:0]    bitIdx, bitIdxNext;
    logic [7:0]    shift, shiftNext;
    logic          txNext;
    logic          pop;
    logic          empty, full, push, accept, statusWr, bitEnd;
    logic [4:0]    countExt;
    logic          unusedBits;

    assign sel      = addr[31:4] == BASE_ADDR[31:4];
    assign empty    = count == '0;
    assign full     = count == DEPTH_C;
    assign push     = we & sel & (addr[3:2] == 2'd0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    assign accept   = push & (~full | pop);
    assign statusWr = we & sel & (addr[3:2] == 2'd1);
    assign bitEnd   = bitCnt == DIV_LAST;
    assign countExt = 5'(count);
    assign unusedBits = ^{addr[1:0], wdata[31:8]};

    always_comb begin
        rdata = '0;
        if (sel && addr[3:2] == 2'd1)
            rdata = {23'd0, countExt, overflow, empty, full, state != IDLE};
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wrPtr] <= wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept)
                wrPtr <= wrPtr + PW'(1);
            if (pop)
                rdPtr <= rdPtr + PW'(1);
            unique case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Set beats clear when both happen in one cycle.
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (statusWr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            bitCnt <= '0;
            bitIdx <= '0;
            shift  <= '0;
            tx     <= 1'b1;
        end else begin
            state  <= stateNext;
            bitCnt <= bitCntNext;
            bitIdx <= bitIdxNext;
            shift  <= shiftNext;
            tx     <= txNext;
        end
    end

    // tx is registered, so its next value is chosen alongside the transition.
    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        bitIdxNext = bitIdx;
        shiftNext  = shift;
        txNext     = tx;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                txNext = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shiftNext  = mem[rdPtr];
                    bitCntNext = '0;
                    stateNext  = START;
                    txNext     = 1'b0;
                end
            end
            START: begin
                if (bitEnd) begin
                    bitCntNext = '0;
                    bitIdxNext = '0;
                    stateNext  = DATA;
                    txNext     = shift[0];
                end else begin
                    bitCntNext = bitCnt + 16'd1;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    bitCntNext = '0;
                    if (bitIdx == 3'd7) begin
                        stateNext = STOP;
                        txNext    = 1'b1;
                    end else begin
                        bitIdxNext = bitIdx + 3'd1;
                        shiftNext  = {1'b0, shift[7:1]};
                        txNext     = shift[1];
                    end
                end else begin
                    bitCntNext = bitCnt + 16'd1;
                end
            end
            STOP: begin
                if (bitEnd) begin
                    bitCntNext = '0;
                    if (!empty) begin
                        pop       = 1'b1;
                        shiftNext = mem[rdPtr];
                        stateNext = START;
                        txNext    = 1'b0;
                    end else begin
                        stateNext = IDLE;
                        txNext    = 1'b1;
                    end
                end else begin
                    bitCntNext = bitCnt + 16'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: doc/sm_uart_tx_mmio.md
# sm_uart_tx_mmio

Memory-mapped UART transmitter on the schoolMIPS data-memory bus, sitting directly downstream of the CPU core's data port. It decodes the core's data-memory address, write-enable and write-data signals. It accepts byte writes into a small transmit FIFO and serialises them as 8N1 frames on a single output pin. Reads return a status word combinationally, so the single-cycle core can use `lw` in the same cycle as the access; the top level muxes `rdata` onto the core's read-data input when `sel` is high.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_4000: register window base; bits [3:0] must be zero.
- `CLK_DIV`, 27: clock cycles per serial bit; legal range 2..65535.
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of two, 2..16.

Ports:
- `clk`, input, 1: clock. One clock domain; everything is on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `addr`, input, 32: byte address from the core's data-memory address output.
- `we`, input, 1: write enable from the core's data-memory write enable.
- `wdata`, input, 32: write data from the core's data-memory write data.
- `sel`, output, 1: combinational; high when `addr[31:4] == BASE_ADDR[31:4]`.
- `rdata`, output, 32: combinational read data, valid when `sel` is high; 0 otherwise.
- `tx`, output, 1: serial line, registered, idle high.

## Operation
- Register map, offset `addr[3:2]`:
  - 0 TXDATA (W): a write pushes `wdata[7:0]`. Reads return 0.
  - 1 STATUS (R/W). Read layout: bit0 busy (FSM not IDLE); bit1 full; bit2 empty; bit3 overflow (sticky); bits[8:4] FIFO count; other bits 0. Any write clears overflow.
  - 2, 3: reserved; reads return 0, writes are ignored.
- Push condition: `we & sel & addr[3:2]==0`.
  - When not full, the byte is stored.
  - When full with no pop in the same cycle, the byte is dropped and overflow is set.
  - When full and a pop occurs in the same cycle, the push is accepted and count is unchanged.
- FIFO: circular buffer with read/write pointers of width log2(FIFO_DEPTH), wrapping modulo FIFO_DEPTH. The count has one extra bit so that full (count == FIFO_DEPTH) is distinguished from empty (count == 0).
- FSM states: IDLE, START, DATA, STOP. `bit_cnt` counts cycles (0..CLK_DIV-1); `bit_idx` counts data bits (0..7).
  - IDLE: `tx`=1. If the FIFO is not empty, pop into shift register and go to START.
  - START: `tx`=0 for CLK_DIV cycles, then go to DATA.
  - DATA: `tx` = shift[0], LSB first. Each bit lasts CLK_DIV cycles, then the register shifts right. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLK_DIV cycles. At the end: if the FIFO is not empty, pop and go to START directly (back-to-back frames, no idle gap); otherwise go to IDLE.
- A frame is exactly 10×CLK_DIV cycles.
- A STATUS write in the same cycle as an overflow event: the overflow set wins.

## Timing
- Reset values: `tx`=1; FSM=IDLE; FIFO empty (pointers and count 0); overflow=0; `bit_cnt`=0; `bit_idx`=0.
  - From reset state: `rdata` for a STATUS read = 32'h0000_0004.
  - `sel` and `rdata` are purely combinational and depend only on reset state and inputs.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronous), and queued bytes are discarded.
- Push at edge E0:
  - count and empty update after E0.
  - At E1 the IDLE FSM pops and enters START; `tx` falls after E1.
  - Latency from write edge to start bit is 1 cycle.
- The pop edge updates count and the FIFO flags; busy is 1 from that edge onward.
- A STATUS read in the same cycle as a push shows pre-push values.
- Busy drops after the final STOP edge when the FIFO is empty.

## Test plan
- Reset, then read STATUS. Required: `rdata`=32'h4 and `tx`=1. With `addr`=BASE_ADDR+16, `sel`=0 and `rdata`=0.
- CLK_DIV=4: write 8'h55 at edge E0. Required:
  - `tx`=0 for cycles 1–4 after E0.
  - Data bits 1,0,1,0,1,0,1,0, 4 cycles each.
  - `tx`=1 stop bit for 4 cycles.
  - STATUS=32'h4 after frame end (edge E0+41).
- Write 8'hA3 and 8'h0F on consecutive cycles. Required:
  - Two frames with no idle gap: the second start bit begins exactly 40 cycles after the first.
  - Count reads 1 while the first frame is in flight.
- FIFO_DEPTH=4: write 6 bytes on consecutive cycles starting from empty/idle.
  - Byte 1 is popped immediately, so 5 are stored; the 6th is dropped.
  - Required: overflow=1, full=1, count=4. Exactly 5 frames are transmitted.
  - After a STATUS write, overflow=0.
- Assert `rst_n`=0 during DATA bit 3 of a frame with 2 bytes queued. Required:
  - `tx`=1 within the same cycle.
  - After release, STATUS=32'h4 and no further frames are sent.
- Full FIFO and STOP-end pop in the same cycle as a TXDATA write. Required: byte accepted, count stays 4, overflow stays 0.
